// File: rtl/input_loader_pkg.sv
// rtl/input_loader_pkg.sv - opcodes, FSM states and target selects shared by the host-side loader blocks
package input_loader_pkg;

  localparam logic [3:0] LOAD_OPCODE = 4'hA;
  localparam logic [3:0] RUN_OPCODE  = 4'h5;

  localparam logic TGT_IN1 = 1'b0;
  localparam logic TGT_IN2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

endpackage

// File: rtl/input_loader.sv
// rtl/input_loader.sv - parses UART load/run commands and writes packed words into the IN1/IN2 arrays
module input_loader
  import input_loader_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter int         DATA_W  = 12,
  parameter logic [3:0] LOAD_OP = LOAD_OPCODE,
  parameter logic [3:0] RUN_OP  = RUN_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              in1_write,
  output logic              in2_write,
  output logic [ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0] data_in,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HI_W  = DATA_W - 8;
  localparam int CNT_W = ADDR_W + 1;

  state_t            state, state_nxt;
  logic              tgt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic [HI_W-1:0]   hi_q;
  logic              xfer;
  logic              hi_bad;

  assign xfer   = rx_valid & rx_ready;
  assign hi_bad = (rx_data >> HI_W) != 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (xfer && rx_data[7:4] == LOAD_OP) state_nxt = ST_LEN;
      ST_LEN:   if (xfer) state_nxt = ST_HI;
      ST_HI:    if (xfer) state_nxt = hi_bad ? ST_IDLE : ST_LO;
      ST_LO:    if (xfer) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = (cnt == CNT_W'(1)) ? ST_IDLE : ST_HI;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // rx_ready is registered from the next state so it is already low during the WRITE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready  <= 1'b0;
      in1_write <= 1'b0;
      in2_write <= 1'b0;
      addr_in   <= '0;
      data_in   <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tgt       <= TGT_IN1;
      cnt       <= '0;
      addr      <= '0;
      hi_q      <= '0;
    end else begin
      rx_ready  <= (state_nxt != ST_WRITE);
      in1_write <= 1'b0;
      in2_write <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (rx_data[7:4] == LOAD_OP) begin
              tgt     <= rx_data[0];
              cpu_rst <= 1'b1;
              err     <= 1'b0;
              busy    <= 1'b1;
            end else if (rx_data[7:4] == RUN_OP) begin
              cpu_rst <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LEN: begin
          if (xfer) begin
            cnt  <= (rx_data == 8'd0) ? CNT_W'(1 << ADDR_W) : CNT_W'(rx_data);
            addr <= '0;
          end
        end
        ST_HI: begin
          if (xfer) begin
            if (hi_bad) begin
              err  <= 1'b1;
              busy <= 1'b0;
            end else begin
              hi_q <= rx_data[HI_W-1:0];
            end
          end
        end
        ST_LO: begin
          if (xfer) begin
            in1_write <= (tgt == TGT_IN1);
            in2_write <= (tgt == TGT_IN2);
            addr_in   <= addr;
            data_in   <= {hi_q, rx_data};
          end
        end
        ST_WRITE: begin
          addr <= addr + 1'b1;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_input_loader.sv
// tb/tb_input_loader.sv - randomized scoreboard bench for input_loader
module tb_input_loader;

  typedef struct packed {
    logic       tgt;
    logic [7:0] addr;
    logic [11:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, in1_write, in2_write, cpu_rst, busy, done, err;
  logic [7:0]  addr_in;
  logic [11:0] data_in;

  int   tests = 0;
  int   fails = 0;
  int   exp_done = 0;
  int   seen_done = 0;
  bit   live = 0;
  bit   prev_done = 0;
  wr_t  exp_q[$];
  logic [11:0] wq[$];

  input_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .in1_write(in1_write), .in2_write(in2_write), .addr_in(addr_in), .data_in(data_in),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) live = rst_n;

  // Monitor: every strobe is popped from the scoreboard and compared
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (in1_write || in2_write) begin
        check("strobe_one_hot", {31'd0, in1_write & in2_write}, 0);
        check("rx_ready_low_in_write", {31'd0, rx_ready}, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", addr_in, data_in);
        end else begin
          e = exp_q.pop_front();
          check("wr_target", {31'd0, in2_write}, {31'd0, e.tgt});
          check("wr_addr", {24'd0, addr_in}, {24'd0, e.addr});
          check("wr_data", {20'd0, data_in}, {20'd0, e.data});
        end
      end else if (live && !rx_ready) begin
        check("rx_ready_outside_write", {31'd0, rx_ready}, 1);
      end
      if (done) begin
        seen_done++;
        check("done_busy_low", {31'd0, busy}, 0);
        check("done_single_cycle", {31'd0, prev_done}, 0);
      end
      prev_done = done;
    end else begin
      prev_done = 0;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 0);
    check({tag, "_strobes"}, {30'd0, in1_write, in2_write}, 0);
    check({tag, "_addr_in"}, {24'd0, addr_in}, 0);
    check({tag, "_data_in"}, {20'd0, data_in}, 0);
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 1);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap = $urandom_range(0, 3);
    int n = 0;
    @(negedge clk);
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %0h not accepted after %0d cycles, required acceptance", b, n);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // mode 0: random words, 1: word i = i, 2: words taken from wq
  task automatic load(input bit tgt, input int n, input int mode);
    logic [11:0] words[$];
    logic [11:0] w;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      w = (mode == 1) ? 12'(i) : (mode == 2) ? wq[i] : 12'($urandom);
      words.push_back(w);
      e.tgt  = tgt;
      e.addr = 8'(i % 256);
      e.data = w;
      exp_q.push_back(e);
    end
    send_byte({4'hA, 3'b000, tgt});
    check("load_busy", {31'd0, busy}, 1);
    check("load_cpu_rst", {31'd0, cpu_rst}, 1);
    check("load_err_clear", {31'd0, err}, 0);
    send_byte(8'(n % 256));
    foreach (words[i]) begin
      send_byte({4'h0, words[i][11:8]});
      send_byte(words[i][7:0]);
    end
    exp_done++;
    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("done_count", seen_done, exp_done);
    check("busy_fell", {31'd0, busy}, 0);
    check("cpu_rst_held", {31'd0, cpu_rst}, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    wr_t e;
    // reset held with traffic present
    rx_valid = 1'b1;
    rx_data  = 8'hA0;
    repeat (4) @(negedge clk);
    check_reset_vals("reset");
    rx_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rx_ready_after_reset", {31'd0, rx_ready}, 1);

    // fixed two-word load to IN1
    wq = '{12'h123, 12'hFFF};
    load(1'b0, 2, 2);
    // payload bytes that look like RUN/LOAD opcodes
    wq = '{12'h050, 12'h0A5, 12'h05A};
    load(1'b1, 3, 2);

    // full 256-word load to IN2
    load(1'b1, 256, 1);

    // bad high byte aborts the load
    send_byte(8'hA0);
    send_byte(8'h01);
    send_byte(8'h10);
    check("abort_err", {31'd0, err}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    send_byte(8'h00);
    check("idle_junk_err", {31'd0, err}, 1);
    repeat (3) @(negedge clk);
    check("abort_no_write", exp_q.size(), 0);
    send_byte(8'h50);
    check("run_cpu_rst", {31'd0, cpu_rst}, 0);
    load(1'b0, 1, 0);

    // unknown opcode then a good load
    send_byte(8'h77);
    check("bad_op_err", {31'd0, err}, 1);
    check("bad_op_busy", {31'd0, busy}, 0);
    load(1'b1, 3, 0);

    repeat (6) load(1'($urandom_range(0, 1)), $urandom_range(1, 6), 0);

    // reset mid-load after the high byte of word 3
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(12'($urandom));
    for (int i = 0; i < 2; i++) begin
      e.tgt  = 1'b0;
      e.addr = 8'(i);
      e.data = wq[i];
      exp_q.push_back(e);
    end
    send_byte(8'hA0);
    send_byte(8'h04);
    for (int i = 0; i < 2; i++) begin
      send_byte({4'h0, wq[i][11:8]});
      send_byte(wq[i][7:0]);
    end
    send_byte({4'h0, wq[2][11:8]});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midload_reset");
    repeat (2) @(negedge clk);
    check("midload_writes", exp_q.size(), 0);
    rst_n = 1'b1;
    load(1'b0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
